idu_rf_prf_rdport: RTL
======================

// Module: idu_rf_prf_rdport
// PURPOSE
//   Read side of the physical register file. Consumes the data/wb_vld outputs of every
//   physical register, keeps a per-preg ready scoreboard, and issues two-source operand
//   reads with a valid/ready handshake. Operands are registered into a single output stage.
//   Sits between rename/dispatch (alloc + read requests) and the execute issue stage.
// PARAMETERS
//   NUM_PREG  64  number of physical registers; preg 0 is the hard-wired zero register
//   PREG_W    6   preg index width, equal to clog2(NUM_PREG)
//   XLEN      64  register data width
//   TAG_W     8   opaque instruction tag carried from request to output
// PORTS
//   clk            in   1                clock
//   rst_clk        in   1                asynchronous active-low reset
//   preg_data      in   NUM_PREG*XLEN    preg i data, bits [i*XLEN +: XLEN]
//   preg_wb_vld    in   NUM_PREG         preg i write-back pulse; data is already updated in that cycle
//   alloc_vld      in   1                rename allocates a new producer for alloc_preg
//   alloc_preg     in   PREG_W           preg being allocated
//   flush          in   1                pipeline flush
//   req_vld        in   1                read request valid
//   req_rdy        out  1                read request accepted when req_vld & req_rdy
//   req_src0_en    in   1                source 0 used
//   req_src0_preg  in   PREG_W           source 0 preg
//   req_src1_en    in   1                source 1 used
//   req_src1_preg  in   PREG_W           source 1 preg
//   req_tag        in   TAG_W            request tag
//   out_vld        out  1                operand bundle valid
//   out_rdy        in   1                downstream accepts when out_vld & out_rdy
//   out_src0_data  out  XLEN             source 0 operand; 0 if the source is unused or preg 0
//   out_src1_data  out  XLEN             source 1 operand; 0 if the source is unused or preg 0
//   out_tag        out  TAG_W            tag of the bundle
// BEHAVIOUR
//   Reset: scoreboard rdy_q all 1. out_vld=0. out_src0_data=0, out_src1_data=0, out_tag=0.
//   Scoreboard, per preg i, updated at the clock edge:
//     - alloc_vld & alloc_preg==i -> rdy_q[i]=0. Alloc wins over a same-cycle preg_wb_vld[i].
//     - else preg_wb_vld[i] -> rdy_q[i]=1.
//     - Preg 0 is always ready; allocation of preg 0 is ignored.
//     - flush does not modify the scoreboard.
//   Effective ready: eff_rdy[i] = rdy_q[i] | preg_wb_vld[i].
//     - This gives a same-cycle bypass: preg_data[i] is already valid while its wb_vld pulses.
//     - An alloc in cycle T is invisible to reads until T+1. A read in T uses the pre-alloc state.
//   Source ready: src_ok = !src_en | eff_rdy[src_preg].
//   Slot free: slot_free = !out_vld | out_rdy.
//   req_rdy = src0_ok & src1_ok & slot_free & !flush. req_rdy does not depend on req_vld.
//   Accept in cycle T:
//     - operands are sampled from preg_data in T.
//     - out_vld=1 with the data and tag in T+1. Latency is 1 cycle.
//   Output stage while out_vld & !out_rdy: all out_* held stable. No new accept.
//   out_rdy & !accept -> out_vld=0 next cycle. Data regs hold their old value.
//   Back-to-back: accept every cycle while out_rdy=1 and sources are ready (full throughput).
//   Flush: out_vld=0 next cycle. No accept in the flush cycle.
//   An out_vld & out_rdy handshake coinciding with flush is still a completed transfer.
//   Asynchronous reset mid-operation: state returns to reset values immediately.
//   Out-of-range preg index (>= NUM_PREG, possible when NUM_PREG is not a power of 2) reads as ready with data 0.
// TESTING
//   1. Reset, then req src0=p5 src1=p6, tag 0x11, out_rdy=1
//      -> req_rdy=1; next cycle out_vld=1, data=0, tag=0x11.
//   2. alloc p7; one cycle later req src0=p7 -> req_rdy=0.
//      Then preg_wb_vld[7] with data 0xDEAD in cycle T -> accept in T; out_src0_data=0xDEAD in T+1.
//   3. alloc_vld for p9 in the same cycle as preg_wb_vld[9] -> rdy_q[9]=0 afterwards;
//      a req on p9 stalls until the next wb pulse.
//   4. out_rdy=0 with out_vld=1 for 3 cycles while req_vld=1
//      -> outputs stable, req_rdy=0. out_rdy=1 -> the pending request is accepted in the same cycle.
//   5. Request with src1_en=0 and src1_preg=p3 (busy) -> accepted; out_src1_data=0.
//      A source of preg 0 also reads 0 and is never busy.
//   6. flush with out_vld=1 and out_rdy=0 -> out_vld=0 next cycle, req_rdy=0 during the flush;
//      the scoreboard is unchanged (busy p7 is still busy).

Source files
------------

// File: rtl/idu_rf_prf_rdport_if.sv
// Read-port bundle between rename/dispatch (request side) and the execute
// issue stage (operand side). The master drives requests and consumes operands.
interface idu_rf_prf_rdport_if #(
    parameter int PREG_W = 6,
    parameter int XLEN   = 64,
    parameter int TAG_W  = 8
);
    logic              req_vld;
    logic              req_rdy;
    logic              req_src0_en;
    logic [PREG_W-1:0] req_src0_preg;
    logic              req_src1_en;
    logic [PREG_W-1:0] req_src1_preg;
    logic [TAG_W-1:0]  req_tag;

    logic              out_vld;
    logic              out_rdy;
    logic [XLEN-1:0]   out_src0_data;
    logic [XLEN-1:0]   out_src1_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output req_vld, req_src0_en, req_src0_preg, req_src1_en, req_src1_preg, req_tag,
        input  req_rdy,
        output out_rdy,
        input  out_vld, out_src0_data, out_src1_data, out_tag
    );

    modport slave (
        input  req_vld, req_src0_en, req_src0_preg, req_src1_en, req_src1_preg, req_tag,
        output req_rdy,
        input  out_rdy,
        output out_vld, out_src0_data, out_src1_data, out_tag
    );
endinterface

// File: rtl/idu_rf_prf_rdport.sv
// Physical register file read port: per-preg ready scoreboard with a
// write-back bypass, two-source operand read, single registered output stage.
module idu_rf_prf_rdport #(
    parameter int NUM_PREG = 64,
    parameter int PREG_W   = $clog2(NUM_PREG),
    parameter int XLEN     = 64,
    parameter int TAG_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic [NUM_PREG*XLEN-1:0] preg_data_i,
    input  logic [NUM_PREG-1:0]      preg_wb_vld_i,
    input  logic                     alloc_vld_i,
    input  logic [PREG_W-1:0]        alloc_preg_i,
    input  logic                     flush_i,
    idu_rf_prf_rdport_if.slave       rd_if
);

    logic [NUM_PREG-1:0] rdy_q;
    logic [NUM_PREG-1:0] rdy_d;
    logic [NUM_PREG-1:0] effRdy;

    logic                src0Ok;
    logic                src1Ok;
    logic [XLEN-1:0]     src0Data;
    logic [XLEN-1:0]     src1Data;
    logic                slotFree;
    logic                reqRdy;
    logic                accept;

    logic                outVld_q;
    logic                outVld_d;
    logic [XLEN-1:0]     outSrc0_q;
    logic [XLEN-1:0]     outSrc0_d;
    logic [XLEN-1:0]     outSrc1_q;
    logic [XLEN-1:0]     outSrc1_d;
    logic [TAG_W-1:0]    outTag_q;
    logic [TAG_W-1:0]    outTag_d;

    // Indices beyond the implemented pregs default to ready.
    function automatic logic lookupRdy(input logic [NUM_PREG-1:0] rdyVec,
                                       input logic [PREG_W-1:0]   idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_PREG; i++) begin
            if (idx == PREG_W'(i)) r = rdyVec[i];
        end
        return r;
    endfunction

    // Preg 0 and indices beyond the implemented pregs read as zero.
    function automatic logic [XLEN-1:0] lookupData(input logic [NUM_PREG*XLEN-1:0] dataVec,
                                                   input logic [PREG_W-1:0]        idx);
        logic [XLEN-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_PREG; i++) begin
            if (idx == PREG_W'(i)) d = dataVec[i*XLEN +: XLEN];
        end
        if (idx == '0) d = '0;
        return d;
    endfunction

    // A preg whose write-back pulses this cycle is readable in the same cycle.
    assign effRdy = rdy_q | preg_wb_vld_i;

    // Resolve readiness and operand value for both sources; unused sources never stall and read zero.
    always_comb begin
        src0Ok   = !rd_if.req_src0_en || lookupRdy(effRdy, rd_if.req_src0_preg);
        src1Ok   = !rd_if.req_src1_en || lookupRdy(effRdy, rd_if.req_src1_preg);
        src0Data = rd_if.req_src0_en ? lookupData(preg_data_i, rd_if.req_src0_preg) : '0;
        src1Data = rd_if.req_src1_en ? lookupData(preg_data_i, rd_if.req_src1_preg) : '0;
    end

    assign slotFree = !outVld_q || rd_if.out_rdy;
    assign reqRdy   = src0Ok && src1Ok && slotFree && !flush_i;
    assign accept   = rd_if.req_vld && reqRdy;

    // Scoreboard next state: allocation beats a same-cycle write-back, preg 0 stays ready.
    always_comb begin
        rdy_d = rdy_q;
        for (int i = 1; i < NUM_PREG; i++) begin
            if (alloc_vld_i && alloc_preg_i == PREG_W'(i)) begin
                rdy_d[i] = 1'b0;
            end else if (preg_wb_vld_i[i]) begin
                rdy_d[i] = 1'b1;
            end
        end
        rdy_d[0] = 1'b1;
    end

    // Output stage next state: flush drops the bundle, accept loads, a drained slot goes empty with data held.
    always_comb begin
        outVld_d  = outVld_q;
        outSrc0_d = outSrc0_q;
        outSrc1_d = outSrc1_q;
        outTag_d  = outTag_q;
        if (flush_i) begin
            outVld_d = 1'b0;
        end else if (accept) begin
            outVld_d  = 1'b1;
            outSrc0_d = src0Data;
            outSrc1_d = src1Data;
            outTag_d  = rd_if.req_tag;
        end else if (rd_if.out_rdy) begin
            outVld_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            rdy_q     <= '1;
            outVld_q  <= 1'b0;
            outSrc0_q <= '0;
            outSrc1_q <= '0;
            outTag_q  <= '0;
        end else begin
            rdy_q     <= rdy_d;
            outVld_q  <= outVld_d;
            outSrc0_q <= outSrc0_d;
            outSrc1_q <= outSrc1_d;
            outTag_q  <= outTag_d;
        end
    end

    assign rd_if.req_rdy       = reqRdy;
    assign rd_if.out_vld       = outVld_q;
    assign rd_if.out_src0_data = outSrc0_q;
    assign rd_if.out_src1_data = outSrc1_q;
    assign rd_if.out_tag       = outTag_q;

endmodule
